// File: rtl/debounce_pkg.sv
// Shared types and constants for the multi-key debounce controller.
package debounce_pkg;

    localparam int unsigned CNT_W                  = 5;
    localparam int unsigned DEFAULT_DEBOUNCE_TICKS = 20;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/key_debounce_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned N_KEYS  = 4,
    parameter int unsigned GRANT_W = $clog2(N_KEYS)
) (
    input  logic [N_KEYS-1:0]  req,
    input  logic [GRANT_W-1:0] ptr,
    output logic               valid_c,
    output logic [GRANT_W-1:0] idx_c
);

    int                 pos;
    logic [GRANT_W-1:0] cand;

    // Walk from the farthest offset down so the nearest request wins last.
    always_comb begin
        valid_c = 1'b0;
        idx_c   = '0;
        pos     = 0;
        cand    = '0;
        for (int k = int'(N_KEYS) - 1; k >= 0; k--) begin
            pos = int'(ptr) + k;
            if (pos >= int'(N_KEYS)) begin
                pos = pos - int'(N_KEYS);
            end
            cand = GRANT_W'(pos);
            if (req[cand]) begin
                valid_c = 1'b1;
                idx_c   = cand;
            end
        end
    end

endmodule

// File: rtl/key_debounce_arbiter.sv
// Debounces N_KEYS active-low keys with one shared tick counter granted round-robin.
// Build option DEBOUNCE_RELEASE_EN: when undefined, releases commit at the grant edge.
module key_debounce_arbiter
    import debounce_pkg::*;
#(
    parameter int unsigned N_KEYS         = 4,
    parameter int unsigned DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS,
    parameter int unsigned GRANT_W        = $clog2(N_KEYS)
) (
    input  logic               clk_out,
    input  logic               timer_rst,
    input  logic [N_KEYS-1:0]  tap_n,
    output logic [N_KEYS-1:0]  key_level,
    output logic [N_KEYS-1:0]  press_pulse,
    output logic [N_KEYS-1:0]  release_pulse,
    output logic               busy,
    output logic [GRANT_W-1:0] grant_idx
);

    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);
    localparam logic [GRANT_W-1:0] IDX_LAST = GRANT_W'(N_KEYS - 1);

    logic [N_KEYS-1:0]  sync1, sync2, raw, mismatch;
    logic               arb_valid;
    logic [GRANT_W-1:0] arb_idx, grant_wrap;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [GRANT_W-1:0] rr_ptr, rr_ptr_next, grant_next;
    logic [N_KEYS-1:0]  level_next, press_next, release_next;
    logic               busy_next;

    // Two-flop synchronizer; idle-high so reset reads as "not pressed".
    always_ff @(posedge clk_out or posedge timer_rst) begin
        if (timer_rst) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= tap_n;
            sync2 <= sync1;
        end
    end

    assign raw        = ~sync2;
    assign mismatch   = raw ^ key_level;
    assign grant_wrap = (grant_idx == IDX_LAST) ? '0 : grant_idx + GRANT_W'(1);

    rr_arbiter #(
        .N_KEYS  (N_KEYS),
        .GRANT_W (GRANT_W)
    ) u_rr_arbiter (
        .req     (mismatch),
        .ptr     (rr_ptr),
        .valid_c (arb_valid),
        .idx_c   (arb_idx)
    );

    always_ff @(posedge clk_out or posedge timer_rst) begin
        if (timer_rst) begin
            state         <= IDLE;
            cnt           <= '0;
            rr_ptr        <= '0;
            grant_idx     <= '0;
            key_level     <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
            busy          <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            rr_ptr        <= rr_ptr_next;
            grant_idx     <= grant_next;
            key_level     <= level_next;
            press_pulse   <= press_next;
            release_pulse <= release_next;
            busy          <= busy_next;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        rr_ptr_next  = rr_ptr;
        grant_next   = grant_idx;
        level_next   = key_level;
        press_next   = '0;
        release_next = '0;

        case (state)
            IDLE: begin
                if (arb_valid) begin
                    grant_next = arb_idx;
                    cnt_next   = '0;
`ifdef DEBOUNCE_RELEASE_EN
                    state_next = COUNT;
`else
                    // Releases are trusted immediately; only presses are filtered.
                    if (key_level[arb_idx]) begin
                        level_next[arb_idx]   = 1'b0;
                        release_next[arb_idx] = 1'b1;
                        state_next            = COMMIT;
                    end else begin
                        state_next = COUNT;
                    end
`endif
                end
            end
            COUNT: begin
                if (!mismatch[grant_idx]) begin
                    state_next  = IDLE;
                    rr_ptr_next = grant_wrap;
                end else if (cnt == CNT_LAST) begin
                    state_next            = COMMIT;
                    level_next[grant_idx] = ~key_level[grant_idx];
                    if (key_level[grant_idx]) begin
                        release_next[grant_idx] = 1'b1;
                    end else begin
                        press_next[grant_idx] = 1'b1;
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            COMMIT: begin
                state_next  = IDLE;
                rr_ptr_next = grant_wrap;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

endmodule

// File: tb/tb_key_debounce_arbiter.sv
// Self-checking bench for key_debounce_arbiter: timestamp-based reference model plus directed and random stimulus.
module tb_key_debounce_arbiter;

    localparam int N  = 4;
    localparam int T  = 20;
    localparam int GW = 2;
`ifdef DEBOUNCE_RELEASE_EN
    localparam bit REL_EN = 1'b1;
`else
    localparam bit REL_EN = 1'b0;
`endif

    logic          clk_out = 1'b0;
    logic          timer_rst;
    logic [N-1:0]  tap_n;
    logic [N-1:0]  key_level, press_pulse, release_pulse;
    logic          busy;
    logic [GW-1:0] grant_idx;

    always #5 clk_out = ~clk_out;

    key_debounce_arbiter #(
        .N_KEYS         (N),
        .DEBOUNCE_TICKS (T),
        .GRANT_W        (GW)
    ) dut (
        .clk_out       (clk_out),
        .timer_rst     (timer_rst),
        .tap_n         (tap_n),
        .key_level     (key_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .busy          (busy),
        .grant_idx     (grant_idx)
    );

    int vectors    = 0;
    int miscompares = 0;
    bit chk_en     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an owner key with the edge it was granted; commit when T edges have elapsed.
    logic [N-1:0] m_level = '0, m_press = '0, m_rel = '0;
    logic [N-1:0] h1 = '1, h2 = '1, m_raw, m_mis;
    int  m_owner = -1, m_grant_edge = 0, m_edge = 0, m_ptr = 0, m_gidx = 0, m_j;
    bit  m_in_commit = 1'b0, m_busy = 1'b0, m_found;

    always @(posedge clk_out or posedge timer_rst) begin
        if (timer_rst) begin
            m_level = '0; m_press = '0; m_rel = '0;
            h1 = '1; h2 = '1;
            m_owner = -1; m_edge = 0; m_ptr = 0; m_gidx = 0;
            m_in_commit = 1'b0; m_busy = 1'b0;
        end else begin
            m_raw = ~h2;
            h2    = h1;
            h1    = tap_n;
            m_edge++;
            m_press = '0;
            m_rel   = '0;
            if (m_in_commit) begin
                m_in_commit = 1'b0;
                m_owner     = -1;
                m_ptr       = (m_gidx + 1) % N;
            end else if (m_owner >= 0) begin
                if (m_raw[m_owner] == m_level[m_owner]) begin
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = -1;
                end else if (m_edge - m_grant_edge == T) begin
                    if (m_level[m_owner]) m_rel[m_owner] = 1'b1;
                    else                  m_press[m_owner] = 1'b1;
                    m_level[m_owner] = ~m_level[m_owner];
                    m_in_commit      = 1'b1;
                end
            end else begin
                m_mis   = m_raw ^ m_level;
                m_found = 1'b0;
                m_j     = 0;
                for (int k = 0; k < N; k++) begin
                    if (!m_found && m_mis[(m_ptr + k) % N]) begin
                        m_found = 1'b1;
                        m_j     = (m_ptr + k) % N;
                    end
                end
                if (m_found) begin
                    m_gidx = m_j;
                    if (!REL_EN && m_level[m_j]) begin
                        m_level[m_j] = 1'b0;
                        m_rel[m_j]   = 1'b1;
                        m_in_commit  = 1'b1;
                    end else begin
                        m_owner      = m_j;
                        m_grant_edge = m_edge;
                    end
                end
            end
            m_busy = m_in_commit || (m_owner >= 0);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk_out) begin
        if (chk_en) begin
            check("key_level", 32'(key_level), 32'(m_level));
            check("press_pulse", 32'(press_pulse), 32'(m_press));
            check("release_pulse", 32'(release_pulse), 32'(m_rel));
            check("busy", 32'(busy), 32'(m_busy));
            check("grant_idx", 32'(grant_idx), 32'(m_gidx));
            check("pulse_onehot0", 32'($onehot0(press_pulse | release_pulse)), 32'd1);
        end
    end

    int d_pe[N], d_re[N], m_pe[N], m_re[N];
    int busy_first, busy_last;

    // Advance n edges, recording the first edge each pulse appears on DUT and model.
    task automatic observe(input int n);
        for (int k = 0; k < N; k++) begin
            d_pe[k] = -1; d_re[k] = -1; m_pe[k] = -1; m_re[k] = -1;
        end
        busy_first = -1;
        busy_last  = -1;
        for (int e = 1; e <= n; e++) begin
            @(negedge clk_out);
            for (int k = 0; k < N; k++) begin
                if (press_pulse[k]   && d_pe[k] < 0) d_pe[k] = e;
                if (release_pulse[k] && d_re[k] < 0) d_re[k] = e;
                if (m_press[k]       && m_pe[k] < 0) m_pe[k] = e;
                if (m_rel[k]         && m_re[k] < 0) m_re[k] = e;
            end
            if (busy) begin
                if (busy_first < 0) busy_first = e;
                busy_last = e;
            end
            #1;
        end
    endtask

    task automatic pulse_reset(input int cycles);
        timer_rst = 1'b1;
        repeat (cycles) begin
            @(negedge clk_out);
            check("rst_level", 32'(key_level), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            #1;
        end
        timer_rst = 1'b0;
    endtask

    int hold[N];

    initial begin
        timer_rst = 1'b1;
        tap_n     = '1;
        repeat (3) @(negedge clk_out);
        chk_en = 1'b1;
        #1 timer_rst = 1'b0;

        // Reset idle
        observe(50);
        check("idle_level", 32'(key_level), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_no_press", 32'(d_pe[0] + d_pe[1] + d_pe[2] + d_pe[3]), 32'(-4));

        // Clean press on key 2
        tap_n[2] = 1'b0;
        observe(30);
        check("press2_dut_edge", 32'(d_pe[2]), 32'd23);
        check("press2_model_edge", 32'(m_pe[2]), 32'd23);
        check("press2_busy_first", 32'(busy_first), 32'd3);
        check("press2_busy_last", 32'(busy_last), 32'd23);
        check("press2_level", 32'(key_level), 32'b0100);

        // Release key 2
        tap_n[2] = 1'b1;
        observe(30);
        check("rel2_dut_edge", 32'(d_re[2]), REL_EN ? 32'd23 : 32'd3);
        check("rel2_model_edge", 32'(m_re[2]), REL_EN ? 32'd23 : 32'd3);

        // Bounce on key 1, then a held press
        tap_n[1] = 1'b0;
        observe(10);
        tap_n[1] = 1'b1;
        observe(20);
        check("bounce_no_pulse", 32'(d_pe[1]), 32'(-1));
        check("bounce_busy", 32'(busy), 32'd0);
        check("bounce_rr_ptr", 32'(dut.rr_ptr), 32'd2);
        tap_n[1] = 1'b0;
        observe(30);
        check("press1_dut_edge", 32'(d_pe[1]), 32'd23);
        check("press1_model_edge", 32'(m_pe[1]), 32'd23);
        tap_n[1] = 1'b1;
        observe(30);
        check("rel1_dut_edge", 32'(d_re[1]), REL_EN ? 32'd23 : 32'd3);

        // Simultaneous press of keys 0 and 3 from rr_ptr = 0
        pulse_reset(2);
        tap_n = 4'b0110;
        observe(50);
        check("sim_key0_edge", 32'(d_pe[0]), 32'd23);
        check("sim_key3_edge", 32'(d_pe[3]), 32'd45);
        check("sim_model_key3", 32'(m_pe[3]), 32'd45);
        tap_n = '1;
        observe(60);
        check("sim_rel0_edge", 32'(d_re[0]), REL_EN ? 32'd23 : 32'd3);
        check("sim_rel3_edge", 32'(d_re[3]), REL_EN ? 32'd45 : 32'd5);

        // Reset in the middle of a key-0 count
        tap_n[0] = 1'b0;
        observe(10);
        pulse_reset(3);
        observe(30);
        check("rstmid_press_edge", 32'(d_pe[0]), 32'd23);
        check("rstmid_model_edge", 32'(m_pe[0]), 32'd23);
        tap_n[0] = 1'b1;
        observe(30);

        // Randomized key activity with occasional resets
        for (int k = 0; k < N; k++) hold[k] = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < N; k++) begin
                if (hold[k] == 0) begin
                    tap_n[k] = 1'($urandom_range(0, 1));
                    hold[k]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8))
                                                           : int'($urandom_range(15, 60));
                end else begin
                    hold[k]--;
                end
            end
            timer_rst = ($urandom_range(0, 999) == 0);
            @(negedge clk_out);
            #1;
        end
        timer_rst = 1'b0;
        tap_n     = '1;
        observe(100);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
